// File: rtl/aes_pkg.sv
// Shared AES key-schedule constants: algorithm encoding, Nk/Nr lookup,
// GF(2^8) doubling used for Rcon, and the key-expansion state enum.
package aes_pkg;

   localparam logic [1:0] ALG_128 = 2'b00;
   localparam logic [1:0] ALG_256 = 2'b01;
   localparam logic [1:0] ALG_192 = 2'b10;

   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_EXPAND = 2'd2
   } state_t;

   // Key length in 32-bit words; the unused encoding 2'b11 falls back to AES-128.
   function automatic logic [3:0] nk_of(input logic [1:0] alg);
      case (alg)
         ALG_256: return 4'd8;
         ALG_192: return 4'd6;
         default: return 4'd4;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] alg);
      case (alg)
         ALG_256: return 4'd14;
         ALG_192: return 4'd12;
         default: return 4'd10;
      endcase
   endfunction

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1; also advances Rcon.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES byte S-box: multiplicative inverse in GF(2^8) (as x^254)
// followed by the fixed affine transform. Shared with the cipher datapath.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);

   logic [7:0] pw;
   logic [7:0] inv;

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p;
      logic [7:0] m;
      p = 8'h00;
      m = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) p = p ^ m;
         m = xtime(m);
      end
      return p;
   endfunction

   // x^(2^k-1) chain up to x^127, one squaring to x^254 = x^-1 (0 maps to 0).
   always_comb begin
      pw = a;
      for (int k = 0; k < 6; k++) begin
         pw = gmul(gmul(pw, pw), a);
      end
      inv = gmul(pw, pw);
      y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key schedule: one 32-bit word per cycle into a 60-word
// store, with a registered 128-bit round-key read port.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_IDLE   | waiting for start; round keys readable, ready if expanded
//  ST_LOAD   | copy latched key words into the store and sliding window
//  ST_EXPAND | derive w[wi] for wi = Nk .. 4*(Nr+1)-1, one per cycle
module aes_key_expand_seq
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   algorithm,
   input  logic [255:0] key,
   output logic         busy,
   output logic         done,
   output logic         ready,
   output logic [3:0]   num_rounds,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_key
);

   state_t        state;
   state_t        state_nxt;
   logic [255:0]  key_q;
   logic [3:0]    nk_q;
   logic [5:0]    wi;
   logic [2:0]    modk;
   logic [7:0]    rcon;
   logic [31:0]   w   [0:59];
   logic [31:0]   win [0:7];

   logic          last_word;
   logic [2:0]    old_pos;
   logic [31:0]   temp;
   logic [31:0]   sub_in;
   logic [31:0]   sub_out;
   logic [31:0]   temp_f;
   logic [31:0]   new_word;

   // Last index is 4*(Nr+1)-1 = 4*Nr+3.
   assign last_word = (wi == {num_rounds, 2'b11});
   // Window holds the newest word in win[7]; w[wi-Nk] therefore sits at 8-Nk.
   assign old_pos   = 3'(4'd8 - nk_q);

   for (genvar g = 0; g < 4; g++) begin : g_subword
      aes_sbox u_sbox (
         .a (sub_in[8*g +: 8]),
         .y (sub_out[8*g +: 8])
      );
   end

   // Next-word datapath: RotWord/SubWord/Rcon at Nk boundaries, extra SubWord for AES-256.
   always_comb begin
      temp   = win[7];
      sub_in = (modk == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
      temp_f = temp;
      if (modk == 3'd0) begin
         temp_f = sub_out ^ {rcon, 24'h0};
      end else if (nk_q == 4'd8 && modk == 3'd4) begin
         temp_f = sub_out;
      end
      new_word = win[old_pos] ^ temp_f;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_LOAD;
         ST_LOAD:   state_nxt = ST_EXPAND;
         ST_EXPAND: if (last_word) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Decoded outputs.
   always_comb begin
      busy = (state != ST_IDLE);
   end

   // Control registers: completion flags, latched parameters, word/mod-Nk counters, Rcon.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done       <= 1'b0;
         ready      <= 1'b0;
         num_rounds <= 4'd0;
         nk_q       <= 4'd4;
         wi         <= 6'd0;
         modk       <= 3'd0;
         rcon       <= RCON_INIT;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  ready      <= 1'b0;
                  num_rounds <= nr_of(algorithm);
                  nk_q       <= nk_of(algorithm);
               end
            end
            ST_LOAD: begin
               wi   <= {2'b00, nk_q};
               modk <= 3'd0;
               rcon <= RCON_INIT;
            end
            ST_EXPAND: begin
               wi   <= wi + 6'd1;
               modk <= (modk == 3'(nk_q - 4'd1)) ? 3'd0 : modk + 3'd1;
               if (modk == 3'd0) rcon <= xtime(rcon);
               if (last_word) begin
                  done  <= 1'b1;
                  ready <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Key latch, word store and sliding window; the store is deliberately not reset.
   always_ff @(posedge clk) begin
      case (state)
         ST_IDLE: begin
            if (start) key_q <= key;
         end
         ST_LOAD: begin
            for (int j = 0; j < 8; j++) begin
               if (j < int'(nk_q)) begin
                  w[j]                  <= key_q[255-32*j -: 32];
                  win[old_pos + 3'(j)]  <= key_q[255-32*j -: 32];
               end
            end
         end
         ST_EXPAND: begin
            w[wi] <= new_word;
            for (int j = 0; j < 7; j++) begin
               win[j] <= win[j+1];
            end
            win[7] <= new_word;
         end
         default: ;
      endcase
   end

   // Registered round-key read; indices beyond Nr (or before any expansion) read as zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_key <= 128'h0;
      end else if (num_rounds != 4'd0 && rd_idx <= num_rounds) begin
         rd_key <= {w[{rd_idx, 2'b00}], w[{rd_idx, 2'b01}],
                    w[{rd_idx, 2'b10}], w[{rd_idx, 2'b11}]};
      end else begin
         rd_key <= 128'h0;
      end
   end

endmodule
